// File: rtl/vec_pkg.sv
// Shared types for the vector command issuer: regfile/element geometry,
// opcode and FSM-state encodings, the packed command record and the opcode legality check.
package vec_pkg;

  localparam int els_p     = 12;
  localparam int vlen_p    = 4;
  localparam int vdw_p     = 8;
  localparam int addr_w_lp = (els_p <= 1) ? 1 : $clog2(els_p);
  localparam int data_w_lp = vlen_p * vdw_p;

  typedef enum logic [3:0] {
    OP_VADD  = 4'b0000,
    OP_VSUB  = 4'b0001,
    OP_VMUL  = 4'b0010,
    OP_SADD  = 4'b0100,
    OP_SSUB  = 4'b0101,
    OP_SMUL  = 4'b0110,
    OP_READ  = 4'b1000,
    OP_WRITE = 4'b1001,
    OP_MMUL  = 4'b1111
  } op_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RESP
  } state_e;

  typedef struct packed {
    logic [3:0]           op;
    logic [addr_w_lp-1:0] addr_a;
    logic [addr_w_lp-1:0] addr_b;
    logic [addr_w_lp-1:0] addr_d;
    logic [vdw_p-1:0]     scalar;
    logic [data_w_lp-1:0] data;
  } cmd_t;

  // Opcodes with op[3]=0 are ALU ops; sub-op 2'b11 is unassigned in both ALU groups.
  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_READ, OP_WRITE, OP_MMUL: return 1'b1;
      default:                    return (op[3] == 1'b0) && (op[1:0] != 2'b11);
    endcase
  endfunction

endpackage

// File: rtl/vec_cmd_issuer_if.sv
// Handshake bundles around the issuer: host command/response side and accelerator side.
// The master modport is the side that originates the command.
interface vec_host_if;
  import vec_pkg::*;

  logic [3:0]           cmd_op_i;
  logic [addr_w_lp-1:0] cmd_addrA_i;
  logic [addr_w_lp-1:0] cmd_addrB_i;
  logic [addr_w_lp-1:0] cmd_addrD_i;
  logic [vdw_p-1:0]     cmd_scalar_i;
  logic [data_w_lp-1:0] cmd_data_i;
  logic                 cmd_v_i;
  logic                 cmd_ready_o;
  logic [data_w_lp-1:0] resp_data_o;
  logic                 resp_v_o;
  logic                 resp_yumi_i;

  modport master (
    output cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrD_i, cmd_scalar_i, cmd_data_i,
    output cmd_v_i, resp_yumi_i,
    input  cmd_ready_o, resp_data_o, resp_v_o
  );

  modport slave (
    input  cmd_op_i, cmd_addrA_i, cmd_addrB_i, cmd_addrD_i, cmd_scalar_i, cmd_data_i,
    input  cmd_v_i, resp_yumi_i,
    output cmd_ready_o, resp_data_o, resp_v_o
  );
endinterface

interface vec_acc_if;
  import vec_pkg::*;

  logic [3:0]           acc_op_o;
  logic [addr_w_lp-1:0] acc_addrA_o;
  logic [addr_w_lp-1:0] acc_addrB_o;
  logic [addr_w_lp-1:0] acc_addrD_o;
  logic [vdw_p-1:0]     acc_scalar_o;
  logic [data_w_lp-1:0] acc_w_data_o;
  logic                 acc_v_o;
  logic                 acc_ready_i;
  logic                 acc_done_i;
  logic [data_w_lp-1:0] acc_r_data_i;
  logic                 acc_r_v_i;
  logic                 acc_yumi_o;

  modport master (
    output acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrD_o, acc_scalar_o, acc_w_data_o,
    output acc_v_o, acc_yumi_o,
    input  acc_ready_i, acc_done_i, acc_r_data_i, acc_r_v_i
  );

  modport slave (
    input  acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrD_o, acc_scalar_o, acc_w_data_o,
    input  acc_v_o, acc_yumi_o,
    output acc_ready_i, acc_done_i, acc_r_data_i, acc_r_v_i
  );
endinterface

// File: rtl/vec_cmd_issuer_timer.sv
// WAIT_DONE watchdog for vec_cmd_issuer; only exists when VEC_CMD_ISSUER_TIMEOUT_EN is defined.
// Counter sits at zero outside WAIT_DONE and flags expiry on the timeout_p-th cycle inside it.
`ifdef VEC_CMD_ISSUER_TIMEOUT_EN
module vec_cmd_issuer_timer #(
  parameter int timeout_p = 255
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic i_en,
  output logic o_expire
);

  localparam int cnt_w_lp = ($clog2(timeout_p + 1) < 8) ? 8 : $clog2(timeout_p + 1);

  logic [cnt_w_lp-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  r_cnt <= '0;
    else if (!i_en)  r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = i_en && (r_cnt == cnt_w_lp'(timeout_p - 1));

endmodule
`endif

// File: rtl/vec_cmd_issuer.sv
// Single-outstanding command issuer between the host command queue and the vector accelerator.
// Optional WAIT_DONE watchdog and timeout_o port are enabled by VEC_CMD_ISSUER_TIMEOUT_EN.
module vec_cmd_issuer
  import vec_pkg::*;
`ifdef VEC_CMD_ISSUER_TIMEOUT_EN
#(
  parameter int timeout_p = 255
)
`endif
(
  input  logic       clk_i,
  input  logic       reset_n_i,
  vec_host_if.slave  host,
  vec_acc_if.master  acc,
  output logic       cmd_done_o,
  output logic       illegal_o,
`ifdef VEC_CMD_ISSUER_TIMEOUT_EN
  output logic       timeout_o,
`endif
  output logic       busy_o
);

  state_e               r_state;
  state_e               w_next_state;
  cmd_t                 r_cmd;
  logic [data_w_lp-1:0] r_resp_data;
  logic                 r_cmd_done;
  logic                 r_illegal;

  logic w_accept;
  logic w_legal;
  logic w_is_read;
  logic w_done_nr;
  logic w_rd_done;
  logic w_timeout;
  logic w_cmd_ready;
  logic w_acc_v;
  logic w_acc_yumi;
  logic w_resp_v;

  assign w_accept  = (r_state == IDLE) && host.cmd_v_i;
  assign w_legal   = is_legal_op(host.cmd_op_i);
  assign w_is_read = (r_cmd.op == OP_READ);
  assign w_done_nr = acc.acc_done_i && !w_is_read;
  // A read only completes once data is offered alongside done; writes never look at r_v.
  assign w_rd_done = acc.acc_done_i && w_is_read && acc.acc_r_v_i;

`ifdef VEC_CMD_ISSUER_TIMEOUT_EN
  logic w_expire;
  logic r_timeout;

  vec_cmd_issuer_timer #(.timeout_p(timeout_p)) u_timer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .i_en      (r_state == WAIT_DONE),
    .o_expire  (w_expire)
  );

  assign w_timeout = w_expire && !w_done_nr && !w_rd_done;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_timeout <= 1'b0;
    else            r_timeout <= w_timeout;
  end

  assign timeout_o = r_timeout;
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: sequential state uses <= so every flop samples pre-edge values in the same delta.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_next_state;
  end

  // NOTE: each always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:      if (w_accept && w_legal)       w_next_state = ISSUE;
      ISSUE:     if (acc.acc_ready_i)           w_next_state = WAIT_DONE;
      WAIT_DONE: if (w_rd_done)                 w_next_state = RESP;
                 else if (w_done_nr || w_timeout) w_next_state = IDLE;
      RESP:      if (host.resp_yumi_i)          w_next_state = IDLE;
      default:                                  w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_cmd_ready = 1'b0;
    w_acc_v     = 1'b0;
    w_acc_yumi  = 1'b0;
    w_resp_v    = 1'b0;
    unique case (r_state)
      IDLE:      w_cmd_ready = reset_n_i;
      ISSUE:     w_acc_v     = 1'b1;
      WAIT_DONE: w_acc_yumi  = w_rd_done;
      RESP:      w_resp_v    = 1'b1;
      default:   ;
    endcase
  end

  // NOTE: command and response registers are reset too, because they drive ports directly.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cmd       <= '0;
      r_resp_data <= '0;
      r_cmd_done  <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_cmd_done <= (r_state == WAIT_DONE) && w_done_nr;
      r_illegal  <= w_accept && !w_legal;
      if (w_accept) begin
        r_cmd <= '{op:     host.cmd_op_i,
                   addr_a: host.cmd_addrA_i,
                   addr_b: host.cmd_addrB_i,
                   addr_d: host.cmd_addrD_i,
                   scalar: host.cmd_scalar_i,
                   data:   host.cmd_data_i};
      end
      if (w_acc_yumi) r_resp_data <= acc.acc_r_data_i;
    end
  end

  assign host.cmd_ready_o = w_cmd_ready;
  assign host.resp_v_o    = w_resp_v;
  assign host.resp_data_o = r_resp_data;

  assign acc.acc_v_o      = w_acc_v;
  assign acc.acc_yumi_o   = w_acc_yumi;
  assign acc.acc_op_o     = r_cmd.op;
  assign acc.acc_addrA_o  = r_cmd.addr_a;
  assign acc.acc_addrB_o  = r_cmd.addr_b;
  assign acc.acc_addrD_o  = r_cmd.addr_d;
  assign acc.acc_scalar_o = r_cmd.scalar;
  assign acc.acc_w_data_o = r_cmd.data;

  assign cmd_done_o = r_cmd_done;
  assign illegal_o  = r_illegal;
  assign busy_o     = (r_state != IDLE);

endmodule

// File: tb/tb_vec_cmd_issuer.sv
// Directed bench for vec_cmd_issuer: stimulus pushes expected issues/events into queues,
// a negedge monitor pops and compares whenever the DUT handshakes or pulses.
module tb_vec_cmd_issuer;
  import vec_pkg::*;

  typedef enum logic [1:0] {EV_DONE, EV_RESP, EV_ILL} ev_e;
  typedef struct {
    ev_e         kind;
    logic [31:0] data;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_done;
  logic illegal;
  logic busy;
`ifdef VEC_CMD_ISSUER_TIMEOUT_EN
  logic to_w;
`endif

  always #5 clk = ~clk;

  vec_host_if h();
  vec_acc_if  a();

`ifdef VEC_CMD_ISSUER_TIMEOUT_EN
  vec_cmd_issuer #(.timeout_p(16)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .host(h), .acc(a),
    .cmd_done_o(cmd_done), .illegal_o(illegal), .timeout_o(to_w), .busy_o(busy));
`else
  vec_cmd_issuer dut (
    .clk_i(clk), .reset_n_i(rst_n), .host(h), .acc(a),
    .cmd_done_o(cmd_done), .illegal_o(illegal), .busy_o(busy));
`endif

  int total = 0;
  int bad   = 0;

  cmd_t iss_q[$];
  ev_t  rsp_q[$];
  cmd_t exp_cmd;
  cmd_t mon_c;
  ev_t  mon_e;
  bit   stable_ok;

  int n_acc_v, n_done, n_ill, n_yumi, n_resp_v, n_ready_low;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    n_acc_v = 0; n_done = 0; n_ill = 0; n_yumi = 0; n_resp_v = 0; n_ready_low = 0;
    stable_ok = 1'b1;
  endtask

  task automatic pop_expect(input ev_e kind, input logic [31:0] data);
    check("event_expected", 64'(rsp_q.size() != 0), 64'd1);
    if (rsp_q.size() != 0) begin
      mon_e = rsp_q.pop_front();
      check("event_kind", 64'(mon_e.kind), 64'(kind));
      if (kind == EV_RESP) check("resp_data", 64'(data), 64'(mon_e.data));
    end
  endtask

  // Monitor: samples on the falling edge, well away from the rising edge the DUT uses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a.acc_v_o)      n_acc_v++;
      if (!h.cmd_ready_o) n_ready_low++;
      if (h.resp_v_o)     n_resp_v++;
      if (a.acc_yumi_o)   n_yumi++;
      if (a.acc_v_o && a.acc_ready_i) begin
        check("issue_expected", 64'(iss_q.size() != 0), 64'd1);
        if (iss_q.size() != 0) begin
          mon_c = iss_q.pop_front();
          check("issue_fields",
                64'({a.acc_op_o, a.acc_addrA_o, a.acc_addrB_o, a.acc_addrD_o,
                     a.acc_scalar_o, a.acc_w_data_o}), 64'(mon_c));
        end
      end
      if (cmd_done) begin n_done++; pop_expect(EV_DONE, 32'h0); end
      if (illegal)  begin n_ill++;  pop_expect(EV_ILL, 32'h0);  end
      if (h.resp_v_o && h.resp_yumi_i) pop_expect(EV_RESP, h.resp_data_o);
    end
  end

  // Advance n cycles; while busy, the accelerator fields must equal the accepted command.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (busy && ({a.acc_op_o, a.acc_addrA_o, a.acc_addrB_o, a.acc_addrD_o,
                    a.acc_scalar_o, a.acc_w_data_o} !== exp_cmd))
        stable_ok = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [addr_w_lp-1:0] aa,
                      input logic [addr_w_lp-1:0] ab, input logic [addr_w_lp-1:0] ad,
                      input logic [7:0] sc, input logic [31:0] d,
                      input bit legal, input bit is_rd, input logic [31:0] rdata);
    ev_t e;
    h.cmd_op_i = op; h.cmd_addrA_i = aa; h.cmd_addrB_i = ab; h.cmd_addrD_i = ad;
    h.cmd_scalar_i = sc; h.cmd_data_i = d; h.cmd_v_i = 1'b1;
    exp_cmd = '{op: op, addr_a: aa, addr_b: ab, addr_d: ad, scalar: sc, data: d};
    if (legal) begin
      iss_q.push_back(exp_cmd);
      e.kind = is_rd ? EV_RESP : EV_DONE;
    end else begin
      e.kind = EV_ILL;
    end
    e.data = rdata;
    rsp_q.push_back(e);
    check("ready_before_send", 64'(h.cmd_ready_o), 64'd1);
    run(1);
    h.cmd_v_i = 1'b0;
  endtask

  logic [3:0] ill_ops [5] = '{4'b1011, 4'b0011, 4'b0111, 4'b1010, 4'b1110};
  logic [3:0] alu_ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    h.cmd_op_i = '0; h.cmd_addrA_i = '0; h.cmd_addrB_i = '0; h.cmd_addrD_i = '0;
    h.cmd_scalar_i = '0; h.cmd_data_i = '0; h.cmd_v_i = 1'b0; h.resp_yumi_i = 1'b0;
    a.acc_ready_i = 1'b0; a.acc_done_i = 1'b0; a.acc_r_data_i = '0; a.acc_r_v_i = 1'b0;
    clr_counts();

    // Reset state
    #12;
    check("rst_ctrl", 64'({h.cmd_ready_o, a.acc_v_o, h.resp_v_o, cmd_done, illegal,
                           a.acc_yumi_o, busy}), 64'd0);
    check("rst_acc_fields", 64'({a.acc_op_o, a.acc_addrA_o, a.acc_addrB_o, a.acc_addrD_o,
                                 a.acc_scalar_o, a.acc_w_data_o}), 64'd0);
    check("rst_resp_data", 64'(h.resp_data_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 64'(h.cmd_ready_o), 64'd1);
    @(posedge clk); #1;

    // Write, accelerator ready at once, done on the second WAIT_DONE cycle
    a.acc_ready_i = 1'b1;
    clr_counts();
    send(4'b1001, 4'd0, 4'd0, 4'd3, 8'h00, 32'h01020201, 1, 0, 32'h0);
    run(2);
    a.acc_done_i = 1'b1;
    run(1);
    a.acc_done_i = 1'b0;
    run(4);
    check("wr_acc_v_cycles", 64'(n_acc_v), 64'd1);
    check("wr_done_pulses", 64'(n_done), 64'd1);
    check("wr_fields_stable", 64'(stable_ok), 64'd1);
    check("wr_no_resp", 64'(n_resp_v), 64'd0);
    check("wr_ready_low", 64'(n_ready_low), 64'd3);

    // Minimum turnaround: ready and done both immediate
    clr_counts();
    a.acc_done_i = 1'b1;
    send(4'b1001, 4'd0, 4'd0, 4'd5, 8'h00, 32'hA5A55A5A, 1, 0, 32'h0);
    run(3);
    a.acc_done_i = 1'b0;
    check("turn_ready_low", 64'(n_ready_low), 64'd2);
    check("turn_done", 64'(n_done), 64'd1);

    // Read with host stalling the response for 5 cycles
    clr_counts();
    send(4'b1000, 4'd8, 4'd0, 4'd0, 8'h00, 32'h0, 1, 1, 32'h080E0C0C);
    run(1);
    a.acc_done_i = 1'b1; a.acc_r_v_i = 1'b1; a.acc_r_data_i = 32'h080E0C0C;
    @(negedge clk);
    check("rd_yumi_comb", 64'(a.acc_yumi_o), 64'd1);
    @(posedge clk); #1;
    a.acc_done_i = 1'b0; a.acc_r_v_i = 1'b0; a.acc_r_data_i = 32'hDEADBEEF;
    run(5);
    check("rd_resp_held", 64'(n_resp_v), 64'd5);
    check("rd_ready_low", 64'(n_ready_low), 64'd7);
    check("rd_resp_data_stable", 64'(h.resp_data_o), 64'h080E0C0C);
    h.resp_yumi_i = 1'b1;
    run(1);
    h.resp_yumi_i = 1'b0;
    run(1);
    check("rd_ready_back", 64'(h.cmd_ready_o), 64'd1);
    check("rd_yumi_count", 64'(n_yumi), 64'd1);
    check("rd_fields_stable", 64'(stable_ok), 64'd1);

    // mmul with 4 stalled issue cycles and done 20 cycles into WAIT_DONE
    a.acc_ready_i = 1'b0;
    clr_counts();
    send(4'b1111, 4'd0, 4'd4, 4'd8, 8'h5A, 32'h11223344, 1, 0, 32'h0);
    run(4);
    a.acc_ready_i = 1'b1;
    run(1);
    run(19);
    a.acc_done_i = 1'b1;
    run(1);
    a.acc_done_i = 1'b0;
    run(2);
    check("mm_acc_v_cycles", 64'(n_acc_v), 64'd5);
    check("mm_done_pulses", 64'(n_done), 64'd1);
    check("mm_no_resp", 64'(n_resp_v), 64'd0);
    check("mm_fields_stable", 64'(stable_ok), 64'd1);

    // Illegal opcodes are dropped with a single illegal_o pulse
    foreach (ill_ops[i]) begin
      clr_counts();
      send(ill_ops[i], 4'd1, 4'd2, 4'd3, 8'h00, 32'h0, 0, 0, 32'h0);
      run(2);
      check($sformatf("ill_pulse_%b", ill_ops[i]), 64'(n_ill), 64'd1);
      check($sformatf("ill_no_acc_v_%b", ill_ops[i]), 64'(n_acc_v), 64'd0);
      check($sformatf("ill_ready_%b", ill_ops[i]), 64'(n_ready_low), 64'd0);
    end

    // Vector and scalar ALU ops: issued with scalar forwarded, complete with cmd_done
    a.acc_done_i = 1'b1;
    foreach (alu_ops[i]) begin
      clr_counts();
      send(alu_ops[i], 4'(i), 4'(i + 1), 4'(11 - i), 8'(8'h30 + i), 32'h0, 1, 0, 32'h0);
      run(3);
      check($sformatf("alu_done_%b", alu_ops[i]), 64'(n_done), 64'd1);
    end
    a.acc_done_i = 1'b0;

    // Reset during WAIT_DONE of a read
    send(4'b1000, 4'd2, 4'd0, 4'd0, 8'h00, 32'h0, 1, 1, 32'h0);
    run(3);
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ctrl", 64'({h.cmd_ready_o, a.acc_v_o, h.resp_v_o, cmd_done, illegal,
                              a.acc_yumi_o, busy}), 64'd0);
    check("midrst_fields", 64'({a.acc_op_o, a.acc_addrA_o, a.acc_addrB_o, a.acc_addrD_o,
                                a.acc_scalar_o, a.acc_w_data_o}), 64'd0);
    rsp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clr_counts();
    a.acc_done_i = 1'b1;
    send(4'b1001, 4'd0, 4'd0, 4'd1, 8'h00, 32'hCAFEF00D, 1, 0, 32'h0);
    run(3);
    a.acc_done_i = 1'b0;
    check("post_rst_done", 64'(n_done), 64'd1);
    check("post_rst_ready", 64'(h.cmd_ready_o), 64'd1);

`ifdef VEC_CMD_ISSUER_TIMEOUT_EN
    begin
      int seen;
      seen = -1;
      clr_counts();
      send(4'b1001, 4'd0, 4'd0, 4'd2, 8'h00, 32'h0, 1, 0, 32'h0);
      void'(rsp_q.pop_back());
      run(1);
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (to_w && seen < 0) seen = i - 1;
        @(posedge clk); #1;
      end
      check("timeout_edges", 64'(seen), 64'd16);
      check("timeout_no_done", 64'(n_done), 64'd0);
      check("timeout_idle", 64'(h.cmd_ready_o), 64'd1);
    end
`endif

    check("queues_drained", 64'(iss_q.size() + rsp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
